// File: rtl/nibble_alu_seq_pkg.sv
// nibble_alu_seq_pkg
//   Shared definitions for the nibble-serial ALU sequencer: operation codes,
//   logic-function codes driven to the 4-bit ALU, controller state encoding
//   and the default nibble count, plus small op-decode helpers.
package nibble_alu_seq_pkg;

  localparam int P_XLEN_DEF = 32;
  localparam int P_NIB_DEF  = 4;
  localparam int C_N_NIB    = P_XLEN_DEF / P_NIB_DEF;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_XOR  = 3'b010,
    OP_OR   = 3'b011,
    OP_AND  = 3'b100,
    OP_SLT  = 3'b101,
    OP_SLTU = 3'b110,
    OP_SEQ  = 3'b111
  } op_e;

  localparam logic [1:0] FN_XOR = 2'b00;
  localparam logic [1:0] FN_OR  = 2'b10;
  localparam logic [1:0] FN_AND = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Compares are computed as A-B so they can reuse the subtract carry chain.
  function automatic logic op_is_sub(op_e op);
    return op inside {OP_SUB, OP_SLT, OP_SLTU, OP_SEQ};
  endfunction

  function automatic logic op_is_logic(op_e op);
    return op inside {OP_XOR, OP_OR, OP_AND};
  endfunction

  function automatic logic [1:0] op_logic_fn(op_e op);
    case (op)
      OP_OR:   return FN_OR;
      OP_AND:  return FN_AND;
      default: return FN_XOR;
    endcase
  endfunction

endpackage

// File: rtl/nibble_alu_seq_ctrl.sv
// nibble_alu_seq_ctrl
//   IDLE/BUSY/DONE sequencing FSM with the per-operation nibble counter.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     req_val_i         request valid (only looked at in IDLE)
//     resp_rdy_i        response accepted (only looked at in DONE)
//     idle_o            in IDLE (doubles as request ready)
//     busy_o            in BUSY, a nibble is consumed on every edge
//     done_o            in DONE (response valid)
//     first_nib_o       BUSY and working on the least significant nibble
//     last_nib_o        BUSY and working on the most significant nibble
module nibble_alu_seq_ctrl
  import nibble_alu_seq_pkg::*;
#(
  parameter int P_N_NIB = C_N_NIB
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_val_i,
  input  logic resp_rdy_i,
  output logic idle_o,
  output logic busy_o,
  output logic done_o,
  output logic first_nib_o,
  output logic last_nib_o
);

  localparam int CW = (P_N_NIB > 1) ? $clog2(P_N_NIB) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cnt_last;

  assign cnt_last = (cnt_q == CW'(P_N_NIB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_val_i) begin
          state_d = ST_BUSY;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        if (cnt_last) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (resp_rdy_i) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign idle_o      = (state_q == ST_IDLE);
  assign busy_o      = (state_q == ST_BUSY);
  assign done_o      = (state_q == ST_DONE);
  assign first_nib_o = busy_o && (cnt_q == '0);
  assign last_nib_o  = busy_o && cnt_last;

endmodule

// File: rtl/nibble_alu_seq.sv
// nibble_alu_seq
//   Feeds one XLEN-bit operation LSB-first, one nibble per cycle, into an
//   external nibble-wide ALU, threads the carry between nibbles, assembles
//   the result and derives SLT/SLTU/SEQ, then returns it over val/rdy.
//   Ports:
//     clk, rst_n                          clock, asynchronous active-low reset
//     req_val_i/req_rdy_o                 request handshake
//     req_op_i, req_a_i, req_b_i          operation and operands
//     alu_in_a_o/alu_in_b_o/alu_in_c_o    nibble operands and carry-in to ALU
//     alu_addsub_fn_o, alu_logic_fn_o     ALU function selects
//     alu_sum_i/alu_carry_i/alu_neq_i/alu_fn_i   ALU results for the nibble
//     resp_val_o/resp_rdy_i               response handshake
//     resp_data_o, resp_carry_o, resp_neq_o      result, final carry, A!=B
module nibble_alu_seq
  import nibble_alu_seq_pkg::*;
#(
  parameter int P_XLEN = P_XLEN_DEF,
  parameter int P_NIB  = P_NIB_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_val_i,
  output logic              req_rdy_o,
  input  logic [2:0]        req_op_i,
  input  logic [P_XLEN-1:0] req_a_i,
  input  logic [P_XLEN-1:0] req_b_i,
  output logic [P_NIB-1:0]  alu_in_a_o,
  output logic [P_NIB-1:0]  alu_in_b_o,
  output logic              alu_in_c_o,
  output logic              alu_addsub_fn_o,
  output logic [1:0]        alu_logic_fn_o,
  input  logic [P_NIB-1:0]  alu_sum_i,
  input  logic              alu_carry_i,
  input  logic              alu_neq_i,
  input  logic [P_NIB-1:0]  alu_fn_i,
  output logic              resp_val_o,
  input  logic              resp_rdy_i,
  output logic [P_XLEN-1:0] resp_data_o,
  output logic              resp_carry_o,
  output logic              resp_neq_o
);

  localparam int C_NNIB = P_XLEN / P_NIB;
  localparam int C_RW   = P_XLEN - P_NIB;

  logic idle, busy, done, first_nib, last_nib, accept;

  nibble_alu_seq_ctrl #(.P_N_NIB(C_NNIB)) u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_val_i   (req_val_i),
    .resp_rdy_i  (resp_rdy_i),
    .idle_o      (idle),
    .busy_o      (busy),
    .done_o      (done),
    .first_nib_o (first_nib),
    .last_nib_o  (last_nib)
  );

  assign accept = idle && req_val_i;

  op_e              op_q;
  logic [P_XLEN-1:0] a_q, b_q;
  // Only the nibbles already produced are kept; the one in flight comes
  // straight from the ALU, so the top nibble needs no storage.
  logic [C_RW-1:0]   res_q;
  logic              carry_q, neq_q;
  logic [P_XLEN-1:0] resp_data_q;
  logic              resp_carry_q, resp_neq_q;

  logic [P_NIB-1:0]  new_nib;
  logic [P_XLEN-1:0] fin_data;
  logic              fin_neq, fin_carry, sign_a, sign_b;

  always_comb begin
    new_nib   = op_is_logic(op_q) ? alu_fn_i : alu_sum_i;
    fin_neq   = neq_q | alu_neq_i;
    fin_carry = op_is_logic(op_q) ? 1'b0 : alu_carry_i;
    // On the last nibble the low nibble of each shifted operand holds the
    // original top nibble, so its MSB is the operand sign.
    sign_a    = a_q[P_NIB-1];
    sign_b    = b_q[P_NIB-1];
    case (op_q)
      OP_SLTU: fin_data = {{(P_XLEN-1){1'b0}}, ~alu_carry_i};
      OP_SLT:  fin_data = {{(P_XLEN-1){1'b0}}, (sign_a != sign_b) ? sign_a : ~alu_carry_i};
      OP_SEQ:  fin_data = {{(P_XLEN-1){1'b0}}, ~fin_neq};
      default: fin_data = {new_nib, res_q};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= OP_ADD;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      carry_q      <= 1'b0;
      neq_q        <= 1'b0;
      resp_data_q  <= '0;
      resp_carry_q <= 1'b0;
      resp_neq_q   <= 1'b0;
    end else if (accept) begin
      op_q    <= op_e'(req_op_i);
      a_q     <= req_a_i;
      b_q     <= req_b_i;
      res_q   <= '0;
      carry_q <= 1'b0;
      neq_q   <= 1'b0;
    end else if (busy) begin
      a_q     <= a_q >> P_NIB;
      b_q     <= b_q >> P_NIB;
      res_q   <= {new_nib, res_q[C_RW-1:P_NIB]};
      carry_q <= alu_carry_i;
      neq_q   <= fin_neq;
      // Response registers change only here so they hold across IDLE/BUSY.
      if (last_nib) begin
        resp_data_q  <= fin_data;
        resp_carry_q <= fin_carry;
        resp_neq_q   <= fin_neq;
      end
    end
  end

  assign req_rdy_o       = idle;
  assign alu_in_a_o      = busy ? a_q[P_NIB-1:0] : '0;
  assign alu_in_b_o      = busy ? b_q[P_NIB-1:0] : '0;
  assign alu_addsub_fn_o = busy && op_is_sub(op_q);
  // Subtract is A + ~B + 1: the +1 enters as carry-in of the first nibble.
  assign alu_in_c_o      = busy && (first_nib ? op_is_sub(op_q) : carry_q);
  assign alu_logic_fn_o  = busy ? op_logic_fn(op_q) : 2'b00;

  assign resp_val_o   = done;
  assign resp_data_o  = resp_data_q;
  assign resp_carry_o = resp_carry_q;
  assign resp_neq_o   = resp_neq_q;

endmodule

// File: tb/tb_nibble_alu_seq.sv
module tb_nibble_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_val;
  logic        req_rdy;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [3:0]  alu_in_a, alu_in_b;
  logic        alu_in_c, alu_addsub_fn;
  logic [1:0]  alu_logic_fn;
  logic [3:0]  alu_sum, alu_fn;
  logic        alu_carry, alu_neq;
  logic        resp_val, resp_rdy;
  logic [31:0] resp_data;
  logic        resp_carry, resp_neq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nibble_alu_seq dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_val_i       (req_val),
    .req_rdy_o       (req_rdy),
    .req_op_i        (req_op),
    .req_a_i         (req_a),
    .req_b_i         (req_b),
    .alu_in_a_o      (alu_in_a),
    .alu_in_b_o      (alu_in_b),
    .alu_in_c_o      (alu_in_c),
    .alu_addsub_fn_o (alu_addsub_fn),
    .alu_logic_fn_o  (alu_logic_fn),
    .alu_sum_i       (alu_sum),
    .alu_carry_i     (alu_carry),
    .alu_neq_i       (alu_neq),
    .alu_fn_i        (alu_fn),
    .resp_val_o      (resp_val),
    .resp_rdy_i      (resp_rdy),
    .resp_data_o     (resp_data),
    .resp_carry_o    (resp_carry),
    .resp_neq_o      (resp_neq)
  );

  // 4-bit datapath ALU sitting beside the sequencer.
  logic [3:0] alu_bop;
  logic [4:0] alu_s;
  always_comb begin
    alu_bop   = alu_addsub_fn ? ~alu_in_b : alu_in_b;
    alu_s     = {1'b0, alu_in_a} + {1'b0, alu_bop} + {4'b0, alu_in_c};
    alu_sum   = alu_s[3:0];
    alu_carry = alu_s[4];
    alu_neq   = (alu_in_a != alu_in_b);
    case (alu_logic_fn)
      2'b10:   alu_fn = alu_in_a | alu_in_b;
      2'b11:   alu_fn = alu_in_a & alu_in_b;
      default: alu_fn = alu_in_a ^ alu_in_b;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic straight from the operation definitions.
  task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] d, output logic c, output logic n);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    n = (a != b);
    c = (a >= b);   // no borrow out of A-B
    case (op)
      3'd0: begin d = s[31:0]; c = s[32]; end
      3'd1: d = a - b;
      3'd2: begin d = a ^ b; c = 1'b0; end
      3'd3: begin d = a | b; c = 1'b0; end
      3'd4: begin d = a & b; c = 1'b0; end
      3'd5: d = {31'b0, ($signed(a) < $signed(b))};
      3'd6: d = {31'b0, (a < b)};
      default: d = {31'b0, (a == b)};
    endcase
  endtask

  // Issues one operation; caller is positioned just after a rising edge.
  // hold>0: resp_rdy is kept low that many cycles in DONE while a stray
  // request is offered.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic [31:0] ed;
    logic        ec, en;
    int          cyc;
    ref_op(op, a, b, ed, ec, en);
    cyc = 0;
    while (req_rdy !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    chk("req_rdy_before_issue", {31'b0, req_rdy}, 32'd1);
    resp_rdy = (hold == 0);
    req_val = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_val = 1'b0;
    cyc = 0;
    while (resp_val !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    chk("latency", cyc, 32'd8);
    chk("resp_data", resp_data, ed);
    chk("resp_carry", {31'b0, resp_carry}, {31'b0, ec});
    chk("resp_neq", {31'b0, resp_neq}, {31'b0, en});
    $display("op=%0d a=0x%08h b=0x%08h -> data=0x%08h carry=%b neq=%b lat=%0d hold=%0d",
             op, a, b, resp_data, resp_carry, resp_neq, cyc, hold);
    for (int i = 0; i < hold; i++) begin
      req_val = 1'b1; req_op = 3'd0; req_a = 32'h1111_1111; req_b = 32'h2222_2222;
      @(posedge clk); #1;
      chk("bp_resp_val", {31'b0, resp_val}, 32'd1);
      chk("bp_resp_data", resp_data, ed);
      chk("bp_req_rdy", {31'b0, req_rdy}, 32'd0);
    end
    req_val  = 1'b0;
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_req_rdy", {31'b0, req_rdy}, 32'd1);
    chk("post_hs_resp_val", {31'b0, resp_val}, 32'd0);
    chk("idle_alu_drive", {20'b0, alu_in_a, alu_in_b, alu_in_c, alu_addsub_fn, alu_logic_fn}, 32'd0);
    if (hold > 0) begin
      @(posedge clk); #1;
      chk("stray_req_dropped", {31'b0, req_rdy}, 32'd1);
    end
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          seen;

    rst_n = 1'b0; req_val = 1'b0; resp_rdy = 1'b1;
    req_op = 3'd0; req_a = '0; req_b = '0;
    #3;
    chk("rst_req_rdy", {31'b0, req_rdy}, 32'd1);
    chk("rst_resp_val", {31'b0, resp_val}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_flags", {30'b0, resp_carry, resp_neq}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 0);   // ADD wrap
    run_op(3'd1, 32'd5, 32'd7, 0);                   // SUB
    run_op(3'd6, 32'd5, 32'd7, 0);                   // SLTU
    run_op(3'd5, 32'hFFFF_FFFF, 32'd1, 0);           // SLT signed
    run_op(3'd6, 32'hFFFF_FFFF, 32'd1, 0);           // SLTU same operands
    run_op(3'd7, 32'h1234_5678, 32'h1234_5678, 0);   // SEQ
    run_op(3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);   // XOR
    run_op(3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);   // OR
    run_op(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);   // AND
    run_op(3'd5, 32'h7FFF_FFFF, 32'h8000_0000, 0);   // SLT: positive vs negative
    run_op(3'd0, 32'h0123_4567, 32'h89AB_CDEF, 3);   // backpressure

    // Reset in the middle of an ADD.
    req_val = 1'b1; req_op = 3'd0; req_a = 32'h1000_0000; req_b = 32'h0000_0fff;
    @(posedge clk); #1;
    req_val = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_req_rdy", {31'b0, req_rdy}, 32'd1);
    chk("midrst_resp_val", {31'b0, resp_val}, 32'd0);
    chk("midrst_resp_data", resp_data, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (resp_val === 1'b1) seen++;
    end
    chk("midrst_no_resp", seen, 32'd0);
    $display("reset mid-operation: response cycles after reset=%0d", seen);
    run_op(3'd0, 32'd3, 32'd4, 0);

    for (int t = 0; t < 40; t++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      if ($urandom_range(0, 4) == 0) rb = {~ra[31], rb[30:0]};
      run_op(rop, ra, rb, (t % 9 == 4) ? 2 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nibble_alu_seq.md
Name: nibble_alu_seq

Overview:
- Nibble-serial operand sequencer for the 4-bit datapath ALU. It feeds that ALU from the issue stage and collects its results.
- Accepts one 32-bit operation from issue and presents LSB-first nibbles to the 4-bit ALU over 8 cycles.
- Threads the carry between nibbles, assembles the 32-bit result, and derives compare results.
- Returns the result to writeback over a val/rdy handshake.

Parameters:
- P_XLEN, 32, operand and result width.
- P_NIB, 4, ALU slice width. P_XLEN must be a multiple of P_NIB.
- C_N_NIB, P_XLEN/P_NIB (8), nibbles per operation. Derived; not overridable.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_val  in  1  request valid.
- req_rdy  out  1  request ready.
- req_op  in  3  operation: 000 ADD, 001 SUB, 010 XOR, 011 OR, 100 AND, 101 SLT, 110 SLTU, 111 SEQ.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- alu_in_a  out  4  current A nibble.
- alu_in_b  out  4  current B nibble.
- alu_in_c  out  1  carry-in for the current nibble.
- alu_addsub_fn  out  1  0=add, 1=sub.
- alu_logic_fn  out  2  00 XOR, 10 OR, 11 AND.
- alu_sum  in  4  ALU sum nibble.
- alu_carry  in  1  ALU carry-out.
- alu_neq  in  1  ALU per-nibble a!=b.
- alu_fn  in  4  ALU logic nibble.
- resp_val  out  1  result valid.
- resp_rdy  in  1  result accepted.
- resp_data  out  32  result.
- resp_carry  out  1  final carry-out of the top nibble (ADD/SUB/SLT/SLTU/SEQ). 0 for logic ops.
- resp_neq  out  1  operands differ (A!=B), all ops.

Behaviour:
- States:
  - IDLE: req_rdy=1.
  - BUSY: nibble counter cnt 0..7.
  - DONE: resp_val=1.
- IDLE: on req_val at an edge, register op, A, B; clear the result, neq and carry registers; cnt<=0; go to BUSY. req_rdy is 1 only in IDLE.
- BUSY, combinational drive:
  - alu_in_a/alu_in_b = bits [3:0] of the shifting operand registers.
  - alu_addsub_fn = 1 for SUB/SLT/SLTU/SEQ, else 0.
  - alu_in_c = addsub_fn when cnt==0, otherwise the registered carry.
  - alu_logic_fn is decoded from op. Outside logic ops it is 00.
- BUSY, each edge:
  - A and B shift right by 4.
  - Result shifts right by 4, with the new nibble entering [31:28]. The new nibble is alu_fn for XOR/OR/AND, else alu_sum.
  - carry<=alu_carry.
  - neq<=neq|alu_neq.
  - The sign bits a31 and b31 are captured when cnt==7, before the shift.
  - cnt increments. At cnt==7 the edge moves to DONE.
- DONE:
  - ADD/SUB/XOR/OR/AND: resp_data = assembled result.
  - SLTU: resp_data = {31'b0, ~carry}.
  - SLT: resp_data = {31'b0, (a31!=b31) ? a31 : ~carry}.
  - SEQ: resp_data = {31'b0, ~neq}.
  - Hold all resp outputs stable until resp_rdy. On the resp_val&resp_rdy edge go to IDLE.
- Latency: accept edge E0; nibbles are consumed on edges E1..E8; resp_val is high after E8. Minimum issue interval is 10 cycles with resp_rdy tied high.
- Outputs outside BUSY:
  - alu_* driven to 0.
  - resp_val=0 outside DONE. resp_data/resp_carry/resp_neq hold their last values. Reset value 0.
- Reset:
  - reset_n low at any time, including mid-BUSY or in DONE, asynchronously forces IDLE.
  - All registers clear to 0: req_rdy=1, resp_val=0, resp_data=0, resp_carry=0, resp_neq=0, cnt=0.
  - An in-flight operation is dropped with no response.
- req_val in BUSY/DONE is ignored; req_rdy=0 there.
- Width rules: carry is exactly 1 bit and is not extended. Arithmetic wraps modulo 2^32.

Decomposition:
- Shared package (include): op-code constants, FN_XOR/FN_OR/FN_AND logic codes, state encodings, C_N_NIB.
- One natural sub-module, nibble_alu_seq_ctrl: FSM plus counter, with outputs busy/done/first_nib.
- Operand, result and flag shift registers stay in the top module.
- The ALU is not instantiated here. It connects beside this block in the datapath. The bench instantiates the real ALU.

Test Plan:
- ADD A=0xFFFFFFFF, B=0x00000001 -> resp_data=0x00000000, resp_carry=1, resp_neq=1; resp_val exactly 8 cycles after the accept edge.
- SUB A=5, B=7 -> resp_data=0xFFFFFFFE, resp_carry=0; then SLTU same operands -> resp_data=1.
- SLT A=0xFFFFFFFF, B=1 -> resp_data=1. SLTU same operands -> 0. SEQ A=B=0x12345678 -> resp_data=1, resp_neq=0.
- XOR A=0xF0F0F0F0, B=0xFF00FF00 -> 0x0FF00FF0. OR -> 0xFFF0FFF0. AND -> 0xF000F000. resp_carry=0 for all three.
- Backpressure: resp_rdy low for 3 cycles in DONE -> resp_val/resp_data stable, req_rdy=0, and a new req_val is not accepted. After handshake, req_rdy=1 next cycle.
- reset_n asserted at cnt==4 of an ADD -> req_rdy=1 and resp_val=0 immediately, with no response. A following ADD 3+4 returns 7.
